// File: rtl/buzzer_scheduler.sv
// rtl/buzzer_scheduler.sv - priority scheduler for CPU beeps, key clicks and alarm bursts on one buzzer
// Owner arbitration (alarm > CPU > key), tick-based durations and per-owner square-wave tone.
module buzzer_scheduler (
    input  logic       CLK0_3,
    input  logic       reset,
    input  logic       tick_20ms,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       key_req,
    input  logic       alarm_req,
    output logic       sound,
    output logic [1:0] owner,
    output logic       busy,
    output logic       key_done,
    output logic       alarm_done
);
    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_CPU_SINGLE = 3'd1;
    localparam logic [2:0] S_CPU_CONT   = 3'd2;
    localparam logic [2:0] S_KEY        = 3'd3;
    localparam logic [2:0] S_ALM_ON     = 3'd4;
    localparam logic [2:0] S_ALM_OFF    = 3'd5;

    localparam logic [5:0] DUR_SINGLE = 6'd10;
    localparam logic [5:0] DUR_KEY    = 6'd1;
    localparam logic [5:0] DUR_ALM    = 6'd5;

    localparam logic [7:0] HALF_CPU = 8'd125;
    localparam logic [7:0] HALF_KEY = 8'd75;
    localparam logic [7:0] HALF_ALM = 8'd250;

    localparam logic [1:0] LAST_BURST = 2'd2;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [2:0] pick_state;
    logic       key_pend;
    logic       alm_pend;
    logic       cpu_single_pend;
    logic       cpu_cont;
    logic [5:0] dur;
    logic [5:0] dur_limit;
    logic [7:0] tone_cnt;
    logic [7:0] half;
    logic       tone_ff;
    logic [1:0] burst;
    logic [1:0] burst_nxt;
    logic       entry;
    logic       ended;
    logic       key_done_nxt;
    logic       alarm_done_nxt;
    logic       stop;
    logic       wr_single;
    logic       wr_cont;
    logic       cont_eff;
    logic       single_eff;
    logic       cpu_owner;
    logic       alm_owner;
    logic       grant_key;
    logic       grant_alm;
    logic       grant_single;
    logic       unused_wr_bits;

    assign unused_wr_bits = ^wr_data[6:1];

    assign stop      = wr_en & ~wr_data[0];
    assign wr_cont   = wr_en & wr_data[0] & wr_data[7];
    assign wr_single = wr_en & wr_data[0] & ~wr_data[7];

    // A stop in this cycle already cancels CPU requests for arbitration on this edge.
    assign cont_eff   = cpu_cont & ~stop;
    assign single_eff = cpu_single_pend & ~stop;

    assign cpu_owner = (state == S_CPU_SINGLE) || (state == S_CPU_CONT);
    assign alm_owner = (state == S_ALM_ON) || (state == S_ALM_OFF);

    always_comb begin
        dur_limit = 6'd0;
        half      = 8'd0;
        case (state)
            S_CPU_SINGLE: begin
                dur_limit = DUR_SINGLE;
                half      = HALF_CPU;
            end
            S_CPU_CONT: half = HALF_CPU;
            S_KEY: begin
                dur_limit = DUR_KEY;
                half      = HALF_KEY;
            end
            S_ALM_ON: begin
                dur_limit = DUR_ALM;
                half      = HALF_ALM;
            end
            S_ALM_OFF: dur_limit = DUR_ALM;
            default: begin
                dur_limit = 6'd0;
                half      = 8'd0;
            end
        endcase
    end

    assign ended = tick_20ms && (dur_limit != 6'd0) && ((dur + 6'd1) == dur_limit);

    always_comb begin
        pick_state = S_IDLE;
        if (alm_pend)
            pick_state = S_ALM_ON;
        else if (cont_eff)
            pick_state = S_CPU_CONT;
        else if (single_eff)
            pick_state = S_CPU_SINGLE;
        else if (key_pend)
            pick_state = S_KEY;
    end

    // Preemption and stop take precedence over a normal end in the same cycle.
    always_comb begin
        state_nxt      = state;
        burst_nxt      = burst;
        entry          = 1'b0;
        key_done_nxt   = 1'b0;
        alarm_done_nxt = 1'b0;
        if (stop && cpu_owner) begin
            state_nxt = S_IDLE;
            entry     = 1'b1;
        end else if (alm_pend && !alm_owner) begin
            state_nxt    = S_ALM_ON;
            burst_nxt    = 2'd0;
            entry        = 1'b1;
            key_done_nxt = (state == S_KEY);
        end else if ((cont_eff || single_eff) && (state == S_IDLE || state == S_KEY)) begin
            state_nxt    = cont_eff ? S_CPU_CONT : S_CPU_SINGLE;
            entry        = 1'b1;
            key_done_nxt = (state == S_KEY);
        end else if (key_pend && state == S_IDLE) begin
            state_nxt = S_KEY;
            entry     = 1'b1;
        end else if (ended) begin
            entry = 1'b1;
            if (state == S_ALM_ON && burst != LAST_BURST) begin
                state_nxt = S_ALM_OFF;
            end else if (state == S_ALM_OFF) begin
                state_nxt = S_ALM_ON;
                burst_nxt = burst + 2'd1;
            end else begin
                state_nxt      = pick_state;
                key_done_nxt   = (state == S_KEY);
                alarm_done_nxt = (state == S_ALM_ON);
                if (pick_state == S_ALM_ON)
                    burst_nxt = 2'd0;
            end
        end
    end

    assign grant_key    = entry && (state_nxt == S_KEY);
    assign grant_single = entry && (state_nxt == S_CPU_SINGLE);
    assign grant_alm    = entry && (state_nxt == S_ALM_ON) && (state != S_ALM_OFF);

    always_ff @(posedge CLK0_3 or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            burst           <= 2'd0;
            key_pend        <= 1'b0;
            alm_pend        <= 1'b0;
            cpu_single_pend <= 1'b0;
            cpu_cont        <= 1'b0;
            key_done        <= 1'b0;
            alarm_done      <= 1'b0;
        end else begin
            state      <= state_nxt;
            burst      <= burst_nxt;
            key_done   <= key_done_nxt;
            alarm_done <= alarm_done_nxt;
            key_pend   <= (key_pend & ~grant_key) | key_req;
            alm_pend   <= (alm_pend & ~grant_alm) | alarm_req;
            if (stop || wr_cont)
                cpu_single_pend <= 1'b0;
            else
                cpu_single_pend <= (cpu_single_pend & ~grant_single) | wr_single;
            if (stop)
                cpu_cont <= 1'b0;
            else if (wr_cont)
                cpu_cont <= 1'b1;
        end
    end

    always_ff @(posedge CLK0_3 or posedge reset) begin
        if (reset) begin
            dur      <= 6'd0;
            tone_cnt <= 8'd0;
            tone_ff  <= 1'b0;
        end else if (entry) begin
            dur      <= 6'd0;
            tone_cnt <= 8'd0;
            tone_ff  <= 1'b0;
        end else begin
            if (state != S_IDLE && tick_20ms)
                dur <= dur + 6'd1;
            if (half != 8'd0) begin
                if (tone_cnt == half - 8'd1) begin
                    tone_cnt <= 8'd0;
                    tone_ff  <= ~tone_ff;
                end else begin
                    tone_cnt <= tone_cnt + 8'd1;
                end
            end
        end
    end

    always_comb begin
        case (state)
            S_CPU_SINGLE, S_CPU_CONT: owner = 2'd1;
            S_KEY:                    owner = 2'd2;
            S_ALM_ON, S_ALM_OFF:      owner = 2'd3;
            default:                  owner = 2'd0;
        endcase
    end

    assign busy  = (owner != 2'd0);
    assign sound = tone_ff & (half != 8'd0);

endmodule

// File: tb/tb_buzzer_scheduler.sv
// tb/tb_buzzer_scheduler.sv - randomized scoreboard bench for buzzer_scheduler
`timescale 1ns/1ps
module tb_buzzer_scheduler;
    logic       CLK0_3;
    logic       reset;
    logic       tick_20ms;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       key_req;
    logic       alarm_req;
    logic       sound;
    logic [1:0] owner;
    logic       busy;
    logic       key_done;
    logic       alarm_done;

    buzzer_scheduler dut (
        .CLK0_3     (CLK0_3),
        .reset      (reset),
        .tick_20ms  (tick_20ms),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .key_req    (key_req),
        .alarm_req  (alarm_req),
        .sound      (sound),
        .owner      (owner),
        .busy       (busy),
        .key_done   (key_done),
        .alarm_done (alarm_done)
    );

    initial CLK0_3 = 1'b0;
    always #5 CLK0_3 = ~CLK0_3;

    localparam int G_IDLE = 0, G_SINGLE = 1, G_CONT = 2, G_KEY = 3, G_ALM = 4;

    typedef struct packed {
        logic [1:0] owner;
        logic       sound;
        logic       busy;
        logic       key_done;
        logic       alarm_done;
    } obs_t;

    obs_t exp_q[$];
    int   n_vec = 0;
    int   n_fail = 0;
    int   n_alarm_done = 0;

    // Reference: current grant, alarm phase 0..4 (even = on), ticks and cycles since grant.
    int m_g = G_IDLE, m_phase = 0, m_ticks = 0, m_age = 0;
    bit m_key = 0, m_alm = 0, m_single = 0, m_cont = 0;

    task automatic check(input string name, input int actual, input int required);
        n_vec++;
        if (actual != required) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h at %0t", name, actual, required, $time);
        end
    endtask

    function automatic obs_t model_obs(input bit kd, input bit ad);
        obs_t o;
        int   half;
        o = '0;
        case (m_g)
            G_SINGLE, G_CONT: o.owner = 2'd1;
            G_KEY:            o.owner = 2'd2;
            G_ALM:            o.owner = 2'd3;
            default:          o.owner = 2'd0;
        endcase
        half = 0;
        if (m_g == G_SINGLE || m_g == G_CONT) half = 125;
        else if (m_g == G_KEY) half = 75;
        else if (m_g == G_ALM && (m_phase % 2) == 0) half = 250;
        o.sound      = (half > 0) ? (((m_age / half) % 2) == 1) : 1'b0;
        o.busy       = (o.owner != 2'd0);
        o.key_done   = kd;
        o.alarm_done = ad;
        return o;
    endfunction

    task automatic model_step();
        bit stop, wcont, wsingle, cc, cs, cpu_own, ends, moved, kd, ad;
        int ng, nph, limit;
        stop    = wr_en && !wr_data[0];
        wcont   = wr_en && wr_data[0] && wr_data[7];
        wsingle = wr_en && wr_data[0] && !wr_data[7];
        cc      = m_cont && !stop;
        cs      = m_single && !stop;
        cpu_own = (m_g == G_SINGLE || m_g == G_CONT);
        limit   = (m_g == G_SINGLE) ? 10 : (m_g == G_KEY) ? 1 : (m_g == G_ALM) ? 5 : 0;
        ends    = tick_20ms && (limit != 0) && (m_ticks + 1 == limit);
        ng = m_g; nph = m_phase; moved = 0; kd = 0; ad = 0;
        if (stop && cpu_own) begin
            ng = G_IDLE; moved = 1;
        end else if (m_alm && m_g != G_ALM) begin
            ng = G_ALM; nph = 0; moved = 1; kd = (m_g == G_KEY);
        end else if ((cc || cs) && (m_g == G_IDLE || m_g == G_KEY)) begin
            ng = cc ? G_CONT : G_SINGLE; moved = 1; kd = (m_g == G_KEY);
        end else if (m_key && m_g == G_IDLE) begin
            ng = G_KEY; moved = 1;
        end else if (ends) begin
            moved = 1;
            if (m_g == G_ALM && m_phase < 4) begin
                nph = m_phase + 1;
            end else begin
                kd  = (m_g == G_KEY);
                ad  = (m_g == G_ALM);
                ng  = m_alm ? G_ALM : cc ? G_CONT : cs ? G_SINGLE : m_key ? G_KEY : G_IDLE;
                nph = 0;
            end
        end
        if (moved && ng == G_ALM && nph == 0) m_alm = 0;
        if (moved && ng == G_KEY) m_key = 0;
        if (moved && ng == G_SINGLE) m_single = 0;
        if (alarm_req) m_alm = 1;
        if (key_req) m_key = 1;
        if (stop || wcont) m_single = 0;
        else if (wsingle) m_single = 1;
        if (stop) m_cont = 0;
        else if (wcont) m_cont = 1;
        if (moved) begin
            m_ticks = 0; m_age = 0;
        end else begin
            if (m_g != G_IDLE && tick_20ms) m_ticks++;
            m_age++;
        end
        m_g = ng; m_phase = nph;
        exp_q.push_back(model_obs(kd, ad));
    endtask

    always @(posedge CLK0_3) begin
        if (reset) begin
            m_g = G_IDLE; m_phase = 0; m_ticks = 0; m_age = 0;
            m_key = 0; m_alm = 0; m_single = 0; m_cont = 0;
            exp_q.push_back('0);
        end else begin
            model_step();
        end
    end

    always @(negedge CLK0_3) begin
        obs_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{owner: owner, sound: sound, busy: busy, key_done: key_done, alarm_done: alarm_done};
            check("scoreboard", int'(a), int'(e));
        end
        if (alarm_done === 1'b1) n_alarm_done++;
    end

    // Compressed 20 ms tick: irregular spacing of 151..351 cycles.
    initial begin
        int gap;
        gap = 40;
        forever begin
            @(negedge CLK0_3);
            if (gap == 0) begin
                tick_20ms = 1'b1;
                gap = $urandom_range(150, 350);
            end else begin
                tick_20ms = 1'b0;
                gap--;
            end
        end
    end

    task automatic pulse_wr(input logic [7:0] d);
        @(negedge CLK0_3); wr_en = 1'b1; wr_data = d;
        @(negedge CLK0_3); wr_en = 1'b0;
    endtask

    task automatic pulse_key();
        @(negedge CLK0_3); key_req = 1'b1;
        @(negedge CLK0_3); key_req = 1'b0;
    endtask

    task automatic pulse_alarm();
        @(negedge CLK0_3); alarm_req = 1'b1;
        @(negedge CLK0_3); alarm_req = 1'b0;
    endtask

    task automatic wait_ticks(input int n);
        int seen;
        seen = 0;
        while (seen < n) begin
            @(posedge CLK0_3);
            if (tick_20ms) seen++;
        end
    endtask

    task automatic wait_owner(input logic [1:0] val, input int budget, input string name);
        int k;
        k = 0;
        do begin
            @(posedge CLK0_3); #1; k++;
        end while (owner != val && k < budget);
        check(name, owner, val);
    endtask

    task automatic wait_done(input bit is_alarm, input int budget, input string name);
        int k;
        k = 0;
        do begin
            @(posedge CLK0_3); #1; k++;
        end while (!(is_alarm ? alarm_done : key_done) && k < budget);
        check(name, is_alarm ? alarm_done : key_done, 1);
    endtask

    task automatic track_segment(input logic [1:0] seg_owner, input int budget,
                                 output int ticks, output int rise, output int fall,
                                 output int end_owner, output int end_kd, output int end_ad);
        int k;
        k = 0; ticks = 0; rise = -1; fall = -1;
        forever begin
            @(posedge CLK0_3);
            if (tick_20ms) ticks++;
            #1;
            k++;
            if (owner != seg_owner || k >= budget) break;
            if (rise < 0 && sound) rise = k;
            else if (rise >= 0 && fall < 0 && !sound) fall = k;
        end
        end_owner = owner; end_kd = key_done; end_ad = alarm_done;
    endtask

    initial begin
        int ticks, rise, fall, eo, ekd, ead, ad_before, sel;
        logic [7:0] d;
        reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; key_req = 1'b0; alarm_req = 1'b0;
        tick_20ms = 1'b0;
        repeat (5) @(negedge CLK0_3);
        check("reset_owner", owner, 0);
        check("reset_sound", sound, 0);
        check("reset_busy", busy, 0);
        check("reset_key_done", key_done, 0);
        check("reset_alarm_done", alarm_done, 0);
        reset = 1'b0;
        repeat (10) @(negedge CLK0_3);

        // single beep: 10 ticks at 125-cycle half period
        pulse_wr(8'h41);
        wait_owner(2'd1, 20, "single_grant");
        track_segment(2'd1, 6000, ticks, rise, fall, eo, ekd, ead);
        check("single_ticks", ticks, 10);
        check("single_first_rise", rise, 125);
        check("single_half_period", fall - rise, 125);
        check("single_end_owner", eo, 0);
        @(negedge CLK0_3);
        check("single_sound_after", sound, 0);

        // continuous for 50 ticks, then stop
        pulse_wr(8'h81);
        wait_owner(2'd1, 20, "cont_grant");
        wait_ticks(50);
        #1 check("cont_held", owner, 1);
        pulse_wr(8'h00);
        check("cont_stop_owner", owner, 0);
        check("cont_stop_sound", sound, 0);

        // key waits behind CPU, alarm preempts, CPU resumes, key after stop
        pulse_wr(8'h81);
        wait_owner(2'd1, 20, "mix_cont_grant");
        repeat (30) @(negedge CLK0_3);
        pulse_key();
        repeat (200) @(negedge CLK0_3);
        check("mix_key_waits", owner, 1);
        ad_before = n_alarm_done;
        pulse_alarm();
        wait_owner(2'd3, 10, "mix_alarm_preempt");
        track_segment(2'd3, 12000, ticks, rise, fall, eo, ekd, ead);
        check("mix_alarm_ticks", ticks, 25);
        check("mix_alarm_rise", rise, 250);
        check("mix_alarm_half", fall - rise, 250);
        check("mix_cont_resume", eo, 1);
        check("mix_alarm_done_edge", ead, 1);
        repeat (5) @(negedge CLK0_3);
        check("mix_alarm_done_count", n_alarm_done - ad_before, 1);
        wait_ticks(1);
        pulse_wr(8'h00);
        wait_owner(2'd2, 10, "mix_key_after_stop");
        track_segment(2'd2, 2000, ticks, rise, fall, eo, ekd, ead);
        check("mix_key_ticks", ticks, 1);
        check("mix_key_rise", rise, 75);
        check("mix_key_end_owner", eo, 0);
        check("mix_key_done", ekd, 1);

        // key preempted by alarm
        wait_ticks(1);
        pulse_key();
        repeat (20) @(negedge CLK0_3);
        check("preempt_key_active", owner, 2);
        pulse_alarm();
        wait_done(1'b0, 20, "preempt_key_done");
        check("preempt_owner_alarm", owner, 3);
        wait_done(1'b1, 12000, "preempt_alarm_done");

        // reset during ALM_OFF
        wait_ticks(1);
        pulse_alarm();
        wait_owner(2'd3, 10, "rst_alarm_grant");
        wait_ticks(7);
        #1 check("rst_in_alm_off", owner, 3);
        ad_before = n_alarm_done;
        @(negedge CLK0_3);
        #2 reset = 1'b1;
        #1;
        check("rst_async_owner", owner, 0);
        check("rst_async_sound", sound, 0);
        check("rst_async_busy", busy, 0);
        check("rst_async_alarm_done", alarm_done, 0);
        repeat (3) @(negedge CLK0_3);
        reset = 1'b0;
        repeat (3000) @(negedge CLK0_3);
        check("rst_no_alarm_done", n_alarm_done - ad_before, 0);
        check("rst_idle_after", owner, 0);

        // randomized traffic against the reference model
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 3) begin
                case ($urandom_range(0, 5))
                    0: d = 8'h00;
                    1: d = 8'h01;
                    2: d = 8'h41;
                    3: d = 8'h81;
                    4: d = 8'hC1;
                    default: d = 8'($urandom);
                endcase
                pulse_wr(d);
            end else if (sel <= 5) begin
                pulse_key();
            end else if (sel == 6) begin
                pulse_alarm();
            end
            repeat ($urandom_range(1, 600)) @(negedge CLK0_3);
        end
        pulse_wr(8'h00);
        repeat (500) @(negedge CLK0_3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
